// File: rtl/fa_count_seq.sv
// fa_count_seq: sequencing stage wrapped around an external 2-bit full adder.
// A run loads a start count and a step. Every unpaused RUN cycle it presents
// count/step to the adder, reloads the adder sum as the new count and counts
// carry-outs. The run ends once WRAPS carries have been accepted. Every adder
// result is also checked against a locally computed expected sum.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             run request, sampled in IDLE only
//   load_val, step    initial count and increment, captured on accepted start
//   pause             holds all RUN state while high
//   clr               synchronous abort/clear (returns to IDLE)
//   add_a, add_b      operands to the adder (count, step while in RUN)
//   add_sum, add_stat result and carry-out from the adder
//   count             registered count
//   busy, done        high in RUN / high for the single DONE cycle
//   wrap_pulse        one-cycle pulse after each accepted carry
//   wrap_cnt          carries accepted in the current run
//   err_step          sticky: start seen with step == 0
//   chk_err           sticky: adder result disagreed with expected sum
module fa_count_seq #(
    parameter int WRAPS = 1  // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] load_val,
    input  logic [1:0] step,
    input  logic       pause,
    input  logic       clr,
    output logic [1:0] add_a,
    output logic [1:0] add_b,
    input  logic [1:0] add_sum,
    input  logic       add_stat,
    output logic [1:0] count,
    output logic       busy,
    output logic       wrap_pulse,
    output logic [3:0] wrap_cnt,
    output logic       done,
    output logic       err_step,
    output logic       chk_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] WRAPS_L = 4'(WRAPS);

    state_t     state, state_nxt;
    logic [1:0] step_r;
    logic       accept;    // start taken in IDLE with a usable step
    logic       bad_start; // start in IDLE with step == 0
    logic       adv;       // one add consumed this cycle
    logic       carry;     // carry accepted this cycle
    logic       last;      // this carry completes the run
    logic       mism;      // adder result disagrees with expectation
    logic [2:0] exp_sum;

    // Outputs decoded straight from state so an async reset clears them
    // without waiting for an edge.
    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign add_a = count;
    assign add_b = busy ? step_r : 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        accept    = 1'b0;
        bad_start = 1'b0;
        adv       = 1'b0;
        carry     = 1'b0;
        last      = 1'b0;
        mism      = 1'b0;
        exp_sum   = {1'b0, add_a} + {1'b0, add_b};
        state_nxt = state;

        case (state)
            IDLE: begin
                accept    = start && (step != 2'd0);
                bad_start = start && (step == 2'd0);
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                adv   = !pause;
                // carry comes only from the adder, never recomputed here
                carry = adv && add_stat;
                last  = carry && ((wrap_cnt + 4'd1) == WRAPS_L);
                mism  = adv && ({add_stat, add_sum} != exp_sum);
                if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            step_r     <= 2'd0;
            wrap_cnt   <= 4'd0;
            wrap_pulse <= 1'b0;
            err_step   <= 1'b0;
            chk_err    <= 1'b0;
        end else if (clr) begin
            // step_r is left alone: it only matters after the next accept
            count      <= 2'd0;
            wrap_cnt   <= 4'd0;
            wrap_pulse <= 1'b0;
            err_step   <= 1'b0;
            chk_err    <= 1'b0;
        end else begin
            wrap_pulse <= carry;
            if (accept) begin
                count    <= load_val;
                step_r   <= step;
                wrap_cnt <= 4'd0;
                chk_err  <= 1'b0;
            end
            if (bad_start) err_step <= 1'b1;
            if (adv)       count    <= add_sum;
            if (carry)     wrap_cnt <= wrap_cnt + 4'd1;
            if (mism)      chk_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fa_count_seq.sv
// Bench for fa_count_seq: two instances (WRAPS = 1 and 2) share stimulus,
// each driven by its own behavioural adder with a carry-kill fault hook.
// A cycle-level reference model and closed-form latency figures supply the
// expected values.
module tb_fa_count_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] load_val = 2'd0;
    logic [1:0] step = 2'd0;

    logic       fault      [2];
    logic [1:0] add_a      [2];
    logic [1:0] add_b      [2];
    logic [1:0] add_sum    [2];
    logic       add_stat   [2];
    logic [1:0] count      [2];
    logic       busy       [2];
    logic       wrap_pulse [2];
    logic [3:0] wrap_cnt   [2];
    logic       done       [2];
    logic       err_step   [2];
    logic       chk_err    [2];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gi
            logic [2:0] s;
            assign s           = {1'b0, add_a[g]} + {1'b0, add_b[g]};
            assign add_sum[g]  = s[1:0];
            assign add_stat[g] = s[2] & ~fault[g];

            fa_count_seq #(.WRAPS(g + 1)) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .start      (start),
                .load_val   (load_val),
                .step       (step),
                .pause      (pause),
                .clr        (clr),
                .add_a      (add_a[g]),
                .add_b      (add_b[g]),
                .add_sum    (add_sum[g]),
                .add_stat   (add_stat[g]),
                .count      (count[g]),
                .busy       (busy[g]),
                .wrap_pulse (wrap_pulse[g]),
                .wrap_cnt   (wrap_cnt[g]),
                .done       (done[g]),
                .err_step   (err_step[g]),
                .chk_err    (chk_err[g])
            );
        end
    endgenerate

    // reference model: phase 0 idle, 1 run, 2 done
    int m_ph [2];
    int m_cnt[2];
    int m_stp[2];
    int m_wc [2];
    bit m_wp [2];
    bit m_es [2];
    bit m_ce [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec(input int i);
        return {17'd0, count[i], busy[i], done[i], wrap_pulse[i], wrap_cnt[i],
                err_step[i], chk_err[i], add_a[i], add_b[i]};
    endfunction

    function automatic logic [31:0] exp_vec(input int i);
        logic [1:0] c;
        logic [1:0] b;
        logic [3:0] w;
        logic [1:0] sp;
        c  = m_cnt[i][1:0];
        w  = m_wc[i][3:0];
        sp = m_stp[i][1:0];
        b  = (m_ph[i] == 1) ? sp : 2'd0;
        return {17'd0, c, m_ph[i] == 1, m_ph[i] == 2, m_wp[i], w,
                m_es[i], m_ce[i], c, b};
    endfunction

    function automatic int n_adds(input int w, input int lv, input int st);
        return (4 * w - lv + st - 1) / st;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_cnt[i] = 0; m_stp[i] = 0; m_wc[i] = 0;
            m_wp[i] = 0; m_es[i] = 0;  m_ce[i] = 0;
        end
    endtask

    // advance the model by one clock using the inputs applied right now
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int s;
            bit c;
            if (clr) begin
                m_ph[i] = 0; m_cnt[i] = 0; m_wc[i] = 0;
                m_wp[i] = 0; m_es[i] = 0;  m_ce[i] = 0;
            end else if (m_ph[i] == 0) begin
                m_wp[i] = 0;
                if (start && step != 0) begin
                    m_cnt[i] = load_val; m_stp[i] = step;
                    m_wc[i] = 0; m_ce[i] = 0; m_ph[i] = 1;
                end else if (start) begin
                    m_es[i] = 1;
                end
            end else if (m_ph[i] == 1) begin
                if (pause) begin
                    m_wp[i] = 0;
                end else begin
                    s = m_cnt[i] + m_stp[i];
                    c = (s >= 4) && !fault[i];
                    if (fault[i] && s >= 4) m_ce[i] = 1;
                    m_cnt[i] = s % 4;
                    m_wp[i]  = c;
                    if (c) begin
                        m_wc[i]++;
                        if (m_wc[i] == i + 1) m_ph[i] = 2;
                    end
                end
            end else begin
                m_wp[i] = 0;
                m_ph[i] = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk($sformatf("state%0d", i), obs_vec(i), exp_vec(i));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy[0] || busy[1] || done[0] || done[1]) && n < 40) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < 40), 32'd1);
    endtask

    task automatic do_run(input logic [1:0] lv, input logic [1:0] st,
                          input int p_at, input int p_len,
                          output int l0, output int l1);
        start = 1'b1; load_val = lv; step = st;
        tick();
        start = 1'b0;
        l0 = -1; l1 = -1;
        for (int c = 1; c <= 60; c++) begin
            pause = (p_at >= 0 && c > p_at && c <= p_at + p_len);
            tick();
            if (done[0] && l0 < 0) l0 = c;
            if (done[1] && l1 < 0) l1 = c;
            if (l0 >= 0 && l1 >= 0) break;
        end
        pause = 1'b0;
        wait_idle();
    endtask

    initial begin
        int l0, l1;
        fault[0] = 1'b0;
        fault[1] = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) chk("reset", obs_vec(i), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // basic counting run, step 1 from 0
        do_run(2'd0, 2'd1, -1, 0, l0, l1);
        chk("lat_w1_s1", 32'(l0), 32'(n_adds(1, 0, 1)));
        chk("lat_w2_s1", 32'(l1), 32'(n_adds(2, 0, 1)));
        chk("wcnt_w1", 32'(wrap_cnt[0]), 32'd1);
        chk("wcnt_w2", 32'(wrap_cnt[1]), 32'd2);

        // carry on every add
        do_run(2'd3, 2'd3, -1, 0, l0, l1);
        chk("lat_w1_s3", 32'(l0), 32'(n_adds(1, 3, 3)));
        chk("lat_w2_s3", 32'(l1), 32'(n_adds(2, 3, 3)));
        chk("chk_clean", 32'(chk_err[1]), 32'd0);

        // pause for three cycles once count reaches 2
        do_run(2'd0, 2'd1, 2, 3, l0, l1);
        chk("lat_w1_pause", 32'(l0), 32'(n_adds(1, 0, 1) + 3));
        chk("lat_w2_pause", 32'(l1), 32'(n_adds(2, 0, 1) + 3));

        // start with zero step
        start = 1'b1; load_val = 2'd2; step = 2'd0;
        tick();
        start = 1'b0;
        chk("err_step", 32'(err_step[0]), 32'd1);
        chk("busy_idle", 32'(busy[0]), 32'd0);
        tick();
        chk("err_sticky", 32'(err_step[0]), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("err_clr", 32'(err_step[0]), 32'd0);

        // start held during RUN with other operands is ignored
        start = 1'b1; load_val = 2'd0; step = 2'd1;
        tick();
        load_val = 2'd2; step = 2'd2;
        tick();
        tick();
        start = 1'b0;
        chk("start_in_run", 32'(count[0]), 32'd2);
        wait_idle();

        // killed carry on a 3+1 add
        start = 1'b1; load_val = 2'd3; step = 2'd1;
        tick();
        start = 1'b0;
        fault[0] = 1'b1; fault[1] = 1'b1;
        tick();
        fault[0] = 1'b0; fault[1] = 1'b0;
        chk("chk_err_set", 32'(chk_err[0]), 32'd1);
        chk("fault_count", 32'(count[0]), 32'd0);
        chk("fault_nopulse", 32'(wrap_pulse[0]), 32'd0);
        tick();
        tick();
        chk("chk_err_sticky", 32'(chk_err[0]), 32'd1);
        wait_idle();

        // clear mid-run
        start = 1'b1; load_val = 2'd0; step = 2'd1;
        tick();
        start = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_count", 32'(count[0]), 32'd0);
        chk("clr_busy", 32'(busy[1]), 32'd0);

        // async reset between edges mid-run
        start = 1'b1; load_val = 2'd1; step = 2'd1;
        tick();
        start = 1'b0;
        tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) chk("async_rst", obs_vec(i), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_run(2'd0, 2'd1, -1, 0, l0, l1);
        chk("lat_after_rst", 32'(l0), 32'(n_adds(1, 0, 1)));

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            start    = ($urandom_range(3) == 0);
            load_val = 2'($urandom);
            step     = 2'($urandom);
            pause    = ($urandom_range(4) == 0);
            clr      = ($urandom_range(29) == 0);
            fault[0] = ($urandom_range(19) == 0);
            fault[1] = ($urandom_range(19) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fa_count_seq.md
# fa_count_seq

Sequencing stage that drives the 2-bit fulladder, registers its result, and counts its carry-outs. Each RUN cycle it presents the held count on `add_a` and the captured step on `add_b`, then loads `add_sum` back as the new count. The run ends after a programmed number of wrap-arounds (`add_stat` = 1). It also cross-checks every adder result against its own expected sum and flags any mismatch.

## Interface
- `WRAPS`, default 1: carries to count before a run finishes; legal range 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a run; sampled in IDLE only.
- `load_val`  in  2  initial count, captured on an accepted start.
- `step`  in  2  increment, captured on an accepted start.
- `pause`  in  1  while high in RUN, all state holds.
- `clr`  in  1  synchronous abort/clear; highest priority after reset.
- `add_a`  out  2  to adder `a`; always equals `count`.
- `add_b`  out  2  to adder `b`; `step_r` in RUN, else 0.
- `add_sum`  in  2  from adder `sum`.
- `add_stat`  in  1  from adder `stat` (carry-out).
- `count`  out  2  registered count.
- `busy`  out  1  high in RUN.
- `wrap_pulse`  out  1  registered; high for one cycle after each accepted carry.
- `wrap_cnt`  out  4  carries accepted in the current run.
- `done`  out  1  high for exactly one cycle, in DONE.
- `err_step`  out  1  sticky; set when a start arrives with step = 0.
- `chk_err`  out  1  sticky; set on an adder result mismatch.

## Operation
- States: IDLE, RUN, DONE (2-bit encoded). Reset → IDLE.
- Reset values: all outputs, `count`, `step_r`, `wrap_cnt` and both error flags are 0.
- IDLE:
  - `start` = 1 and `step` != 0: load `count` ← `load_val` and `step_r` ← `step`; clear `wrap_cnt` and `chk_err`; go to RUN.
  - `start` = 1 and `step` = 0: stay in IDLE; set `err_step`. No other state changes.
- RUN, `pause` = 0, each cycle:
  - `count` ← `add_sum`.
  - If `add_stat` = 1: `wrap_cnt` increments and `wrap_pulse` is 1 next cycle. If the new `wrap_cnt` equals `WRAPS`, go to DONE.
- RUN, `pause` = 1: `count`, `wrap_cnt` and state hold. `wrap_pulse` is 0. The adder check is suppressed.
- DONE: `done` = 1 and `busy` = 0. Unconditionally go to IDLE next cycle. `count` and `wrap_cnt` hold until the next accepted start.
- `start` is ignored in RUN and DONE; it is not queued.
- `clr` = 1 in any state: next state is IDLE; `count`, `wrap_cnt`, `wrap_pulse`, `err_step` and `chk_err` go to 0. `clr` overrides a simultaneous `start`.
- Adder check (RUN, not paused): expected = {1'b0,`add_a`} + {1'b0,`add_b`}, 3 bits. If {`add_stat`,`add_sum`} differs from expected, set `chk_err`. The check runs every such cycle.
- Arithmetic is modulo 4 on `count`; the carry is taken only from `add_stat`, never recomputed internally.
- `wrap_cnt` never exceeds `WRAPS`, because the run ends on reaching it.

## Timing
- Start accepted at edge k (state = RUN after k):
  - First add presented during cycle k..k+1.
  - First `count` update at edge k+1.
- One add per unpaused RUN cycle; the adder path is combinational within the cycle.
- `wrap_pulse` and the DONE transition take effect at the same edge as the carrying update. `done` is therefore visible in the same cycle as the last `wrap_pulse`.
- IDLE is reached one edge after DONE. The earliest new start is accepted at the edge after that, in IDLE.
- Latency, from the start edge to `done`: (number of unpaused adds needed to produce `WRAPS` carries) + paused cycles.
- `rst_n` low at any time, including mid-RUN: outputs go to reset values immediately, without waiting for a clock edge.
- The first edge after release with `start` = 1 and `step` != 0 in IDLE begins a run.

## Test plan
- `WRAPS` = 1, `load_val` = 0, `step` = 1, start at edge k:
  - `count` = 1,2,3,0 at edges k+1..k+4.
  - `wrap_pulse` and `done` both high for one cycle after k+4; `wrap_cnt` = 1.
  - `busy` low after k+4.
- `WRAPS` = 2, `load_val` = 3, `step` = 3:
  - `count` = 2 then 1; carries on both adds.
  - `done` after the 2nd add; `wrap_cnt` = 2.
  - `chk_err` stays 0.
- Pause: run with `load_val` = 0, `step` = 1, `pause` high for 3 cycles after `count` = 2:
  - `count` holds at 2 and `wrap_pulse` stays 0 while paused.
  - `done` arrives 3 cycles later than in the unpaused run.
- Errors and start handling:
  - `start` with `step` = 0 → state stays IDLE, `busy` = 0, `err_step` = 1 until `clr`.
  - A `start` asserted in RUN has no effect.
- Fault and abort:
  - Bench forces `add_stat` = 0 on a 3+1 add → `chk_err` = 1 and sticky; `count` = 0; no `wrap_pulse`.
  - `clr` mid-run → IDLE next cycle with `count` = 0.
- Async reset: drive `rst_n` low mid-RUN between clock edges → all outputs 0 immediately. After release, a fresh start runs normally.
